dac_serial_loader: RTL and testbench

//  Parametrised serial loader for DAC7611-class 3-wire DACs (SCLK/SDI/LD/CLR).

---
 rtl/dac_serial_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_dac_serial_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_loader.sv
// Serial loader for DAC7611-class 3-wire DACs: shifts DATA_W-bit words out on shared
// SCLK/SDI, then strobes the addressed chip's LD line; also issues CLR pulses on request.
module dac_serial_loader #(
    parameter int DATA_W    = 12,
    parameter int NUM_CH    = 1,
    parameter int HALF_CYC  = 2,
    parameter int LD_DLY    = 2,
    parameter int LD_W      = 2,
    parameter int CLR_W     = 1,
    parameter int MSB_FIRST = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sdi,
    output logic [NUM_CH-1:0] ld_n,
    output logic              clr_n
);

    localparam int HC_W  = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CMAX  = (LD_DLY > LD_W) ? ((LD_DLY > CLR_W) ? LD_DLY : CLR_W)
                                           : ((LD_W > CLR_W) ? LD_W : CLR_W);
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(LD_DLY - 1);
    localparam logic [CNT_W-1:0] LDW_LAST = CNT_W'(LD_W - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        HOLD  = 3'd2,
        LOAD  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   half_q, half_d;
    logic              hi_q, hi_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              clr_pend_q, clr_pend_d;

    logic              in_ready_d, busy_d, done_d, sclk_d, sdi_d, clr_n_d;
    logic [NUM_CH-1:0] ld_n_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            half_q     <= '0;
            hi_q       <= 1'b0;
            bit_q      <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            ch_q       <= '0;
            clr_pend_q <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sclk       <= 1'b1;
            sdi        <= 1'b0;
            ld_n       <= '1;
            clr_n      <= 1'b1;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            hi_q       <= hi_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ch_q       <= ch_d;
            clr_pend_q <= clr_pend_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            sclk       <= sclk_d;
            sdi        <= sdi_d;
            ld_n       <= ld_n_d;
            clr_n      <= clr_n_d;
        end
    end

    // Every output is computed here as its next value so that all pins come
    // straight from flops and cannot glitch.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        hi_d       = hi_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ch_d       = ch_q;
        clr_pend_d = clr_pend_q | (clr_req & (state_q != IDLE));
        in_ready_d = in_ready;
        busy_d     = busy;
        done_d     = 1'b0;
        sclk_d     = sclk;
        sdi_d      = sdi;
        ld_n_d     = ld_n;
        clr_n_d    = clr_n;

        case (state_q)
            IDLE: begin
                if (clr_req || clr_pend_q) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_n_d    = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (in_valid && in_ready) begin
                    state_d    = SHIFT;
                    half_d     = '0;
                    hi_d       = 1'b0;
                    bit_d      = '0;
                    ch_d       = in_ch;
                    sclk_d     = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    if (MSB_FIRST != 0) begin
                        sdi_d   = in_data[DATA_W-1];
                        shreg_d = in_data << 1;
                    end else begin
                        sdi_d   = in_data[0];
                        shreg_d = in_data >> 1;
                    end
                end else begin
                    in_ready_d = 1'b1;
                    sdi_d      = 1'b0;
                end
            end

            SHIFT: begin
                if (half_q != HC_LAST) begin
                    half_d = half_q + 1'b1;
                end else begin
                    half_d = '0;
                    if (!hi_q) begin
                        hi_d   = 1'b1;
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        // sclk stays high and sdi keeps the last bit through HOLD
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        hi_d   = 1'b0;
                        sclk_d = 1'b0;
                        if (MSB_FIRST != 0) begin
                            sdi_d   = shreg_q[DATA_W-1];
                            shreg_d = shreg_q << 1;
                        end else begin
                            sdi_d   = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end
            end

            HOLD: begin
                if (cnt_q == DLY_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    ld_n_d  = '1;
                    // an out-of-range channel matches no line, so nothing strobes
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == CH_W'(i)) ld_n_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LOAD: begin
                if (cnt_q == LDW_LAST) begin
                    state_d    = IDLE;
                    ld_n_d     = '1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    sdi_d      = 1'b0;
                    in_ready_d = !clr_pend_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d    = IDLE;
                    clr_n_d    = 1'b1;
                    busy_d     = 1'b0;
                    in_ready_d = !clr_pend_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                sclk_d     = 1'b1;
                sdi_d      = 1'b0;
                ld_n_d     = '1;
                clr_n_d    = 1'b1;
                busy_d     = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_serial_loader.sv
// Bench for dac_serial_loader: two instances (default and a narrow LSB-first one)
// checked cycle by cycle against waveforms computed from the word/timing rules.
module tb_dac_serial_loader;

    localparam int DW = 12;
    // instance B parameters
    localparam int B_NCH = 3, B_H = 1, B_DLY = 1, B_LDW = 3, B_CLRW = 2, B_MSB = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic          a_valid = 1'b0, a_ready, a_clr = 1'b0, a_busy, a_done, a_sclk, a_sdi, a_clr_n;
    logic [DW-1:0] a_data = '0;
    logic [0:0]    a_ch = '0;
    logic [0:0]    a_ld_n;

    logic          b_valid = 1'b0, b_ready, b_clr = 1'b0, b_busy, b_done, b_sclk, b_sdi, b_clr_n;
    logic [DW-1:0] b_data = '0;
    logic [1:0]    b_ch = '0;
    logic [2:0]    b_ld_n;

    int checks = 0, passes = 0, fails = 0;

    always #5 clk = ~clk;

    dac_serial_loader dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_ch(a_ch), .clr_req(a_clr), .busy(a_busy), .done(a_done),
        .sclk(a_sclk), .sdi(a_sdi), .ld_n(a_ld_n), .clr_n(a_clr_n)
    );

    dac_serial_loader #(
        .DATA_W(DW), .NUM_CH(B_NCH), .HALF_CYC(B_H), .LD_DLY(B_DLY), .LD_W(B_LDW),
        .CLR_W(B_CLRW), .MSB_FIRST(B_MSB)
    ) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_ch(b_ch), .clr_req(b_clr), .busy(b_busy), .done(b_done),
        .sclk(b_sclk), .sdi(b_sdi), .ld_n(b_ld_n), .clr_n(b_clr_n)
    );

    function automatic int p_h(int d);    return (d == 0) ? 2 : B_H;    endfunction
    function automatic int p_nch(int d);  return (d == 0) ? 1 : B_NCH;  endfunction
    function automatic int p_msb(int d);  return (d == 0) ? 1 : B_MSB;  endfunction
    function automatic int p_dly(int d);  return (d == 0) ? 2 : B_DLY;  endfunction
    function automatic int p_ldw(int d);  return (d == 0) ? 2 : B_LDW;  endfunction
    function automatic int p_clrw(int d); return (d == 0) ? 1 : B_CLRW; endfunction
    function automatic int busy_len(int d); return DW*2*p_h(d) + p_dly(d) + p_ldw(d); endfunction

    // {sclk, sdi, ld_n[3:0] (unused lines read 1), clr_n, busy, done, in_ready}
    function automatic logic [9:0] mk(logic s, logic q, logic [3:0] ld, logic c,
                                      logic b, logic dn, logic r);
        return {s, q, ld, c, b, dn, r};
    endfunction

    function automatic logic [9:0] obs(int d);
        if (d == 0) return {a_sclk, a_sdi, 3'b111, a_ld_n, a_clr_n, a_busy, a_done, a_ready};
        return {b_sclk, b_sdi, 1'b1, b_ld_n, b_clr_n, b_busy, b_done, b_ready};
    endfunction

    localparam logic [9:0] RST_VEC  = {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [9:0] IDLE_VEC = {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};

    // Expected pins c cycles after the accepting edge of a word.
    function automatic logic [9:0] exp_word(int d, int c, logic [DW-1:0] data, int ch, logic pend);
        int h, sh, bi;
        logic [3:0] ld;
        logic lastbit;
        h  = p_h(d);
        sh = DW * 2 * h;
        ld = 4'hF;
        lastbit = (p_msb(d) != 0) ? data[0] : data[DW-1];
        if (c < sh) begin
            bi = (p_msb(d) != 0) ? DW - 1 - c / (2*h) : c / (2*h);
            return mk((c % (2*h)) >= h, data[bi], ld, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        if (c < sh + p_dly(d)) return mk(1'b1, lastbit, ld, 1'b1, 1'b1, 1'b0, 1'b0);
        if (c < busy_len(d)) begin
            if (ch < p_nch(d)) ld[ch] = 1'b0;
            return mk(1'b1, lastbit, ld, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        return mk(1'b1, 1'b0, ld, 1'b1, 1'b0, 1'b1, !pend);
    endfunction

    task automatic check(input int d, input string tag, input int c, input logic [9:0] e);
        logic [9:0] o;
        o = obs(d);
        checks++;
        assert (o === e) passes++;
        else begin
            fails++;
            $error("FAIL %s dut%0d cyc%0d got=%b exp=%b", tag, d, c, o, e);
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic [DW-1:0] data, input int ch);
        if (d == 0) begin a_valid = v; a_data = data; a_ch = 1'(ch); end
        else        begin b_valid = v; b_data = data; b_ch = 2'(ch); end
    endtask

    task automatic set_clr(input int d, input logic v);
        if (d == 0) a_clr = v; else b_clr = v;
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge of the done cycle.
    task automatic do_word(input int d, input logic [DW-1:0] data, input int ch,
                           input int clr_at, input int rst_at);
        logic pend;
        pend = 1'b0;
        set_in(d, 1'b1, data, ch);
        for (int c = 0; c <= busy_len(d); c++) begin
            @(negedge clk);
            set_in(d, 1'b0, 12'($urandom), int'($urandom_range(0, 3)));
            if (c == clr_at + 1) set_clr(d, 1'b0);
            check(d, "word", c, exp_word(d, c, data, ch, pend));
            if (c == clr_at) begin set_clr(d, 1'b1); pend = 1'b1; end
            if (c == rst_at) begin
                #1 reset = 1'b0;
                #1 check(d, "async_rst", c, RST_VEC);
                return;
            end
        end
    endtask

    task automatic do_clear(input int d, input logic trig, input logic hold,
                            input logic with_word, input logic [DW-1:0] wdata, input int wch);
        if (trig) set_clr(d, 1'b1);
        if (with_word) set_in(d, 1'b1, wdata, wch);
        for (int c = 0; c <= p_clrw(d); c++) begin
            @(negedge clk);
            if (c == 0 && !hold) set_clr(d, 1'b0);
            if (c < p_clrw(d))
                check(d, "clear", c, mk(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
            else
                check(d, "clear_end", c, mk(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, !hold));
        end
    endtask

    task automatic idle_chk(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check(0, "idle", c, IDLE_VEC);
            check(1, "idle", c, IDLE_VEC);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check(0, "reset", 0, RST_VEC);
        check(1, "reset", 0, RST_VEC);
        reset = 1'b1;
        #1 check(0, "ready_before_edge", 0, RST_VEC);
        idle_chk(2);

        // default instance: 12'h555 ch0, then back-to-back random words incl. ch out of range
        do_word(0, 12'h555, 0, -1, -1);
        for (int i = 0; i < 4; i++) do_word(0, 12'($urandom), int'($urandom_range(0, 1)), -1, -1);
        do_word(0, 12'hFFF, 1, -1, -1);
        idle_chk(2);

        // narrow instance: LSB first, ch2, then out-of-range ch3, then random
        do_word(1, 12'h801, 2, -1, -1);
        do_word(1, 12'hA5C, 3, -1, -1);
        for (int i = 0; i < 3; i++) do_word(1, 12'($urandom), int'($urandom_range(0, 3)), -1, -1);
        idle_chk(1);

        // clear request mid-shift: load completes, clear follows the done cycle
        do_word(0, 12'h3C9, 0, 10, -1);
        do_clear(0, 1'b0, 1'b0, 1'b0, '0, 0);
        do_word(0, 12'h0F0, 0, -1, -1);
        idle_chk(1);

        // clear and word in the same idle cycle: clear first
        do_clear(0, 1'b1, 1'b0, 1'b1, 12'h6B2, 0);
        do_word(0, 12'h6B2, 0, -1, -1);
        do_clear(1, 1'b1, 1'b0, 1'b1, 12'h1E7, 1);
        do_word(1, 12'h1E7, 1, -1, -1);
        idle_chk(1);

        // held clear request re-triggers with one idle cycle between pulses
        do_clear(0, 1'b1, 1'b1, 1'b0, '0, 0);
        do_clear(0, 1'b0, 1'b1, 1'b0, '0, 0);
        do_clear(0, 1'b0, 1'b0, 1'b0, '0, 0);
        idle_chk(1);

        // reset in the middle of a shift
        do_word(0, 12'hABC, 0, -1, 20);
        check(1, "async_rst", 0, RST_VEC);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check(0, "in_reset", c, RST_VEC);
            check(1, "in_reset", c, RST_VEC);
        end
        reset = 1'b1;
        #1 check(0, "release", 0, RST_VEC);
        idle_chk(4);
        do_word(0, 12'($urandom), 0, -1, -1);
        idle_chk(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
